nibble_add_sched: RTL and testbench

Sequencer and arbiter that shares one 4-bit prefix adder slice between two requesters. Operands of WIDTH bits are added serially, one nibble per cycle, least significant nibble first, with the carry registered between nibbles. The block sits between two operand producers and a single result consumer. It replaces a full-width adder where area matters more than latency.

---
 rtl/nibble_sched_pkg.sv | 14 +
 rtl/nibble_add4.sv | 38 +++
 rtl/nibble_add_sched.sv | 152 +++++++++++++++
 tb/tb_nibble_add_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_sched_pkg.sv
// Shared types and constants for the nibble-serial adder scheduler.
package nibble_sched_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic req_id_t;

endpackage

// File: rtl/nibble_add4.sv
// 4-bit parallel-prefix adder slice with carry in and carry out; purely combinational.
module nibble_add4
   import nibble_sched_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout
);

   logic [NIB_W-1:0] g;
   logic [NIB_W-1:0] p;
   logic [NIB_W-1:0] c;
   logic             g10, p10, g32, p32, g20, p20, g30, p30;

   assign g = a & b;
   assign p = a ^ b;

   // Two-level prefix tree over (generate, propagate) pairs.
   assign g10 = g[1] | (p[1] & g[0]);
   assign p10 = p[1] & p[0];
   assign g32 = g[3] | (p[3] & g[2]);
   assign p32 = p[3] & p[2];
   assign g20 = g[2] | (p[2] & g10);
   assign p20 = p[2] & p10;
   assign g30 = g32 | (p32 & g10);
   assign p30 = p32 & p10;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g10 | (p10 & cin);
   assign c[3] = g20 | (p20 & cin);

   assign s    = p ^ c;
   assign cout = g30 | (p30 & cin);

endmodule

// File: rtl/nibble_add_sched.sv
// Round-robin scheduler sharing one 4-bit adder slice between two requesters; NIBBLE_SCHED_INC_EN adds carry-in ports.
// Result valid WIDTH/4 cycles after accept; rsp_ready low holds DONE and keeps both requester readies low.
module nibble_add_sched
   import nibble_sched_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
`ifdef NIBBLE_SCHED_INC_EN
   input  logic             req0_inc,
   input  logic             req1_inc,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id,
   output logic             busy
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   state_t           state_q, state_d;
   req_id_t          last_grant_q, last_grant_d;
   req_id_t          id_q, id_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] nib_cnt_q, nib_cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;

   logic             grant_vld;
   req_id_t          grant_id;
   logic             inc_sel;
   int               nib_base;
   logic [NIB_W-1:0] slice_a, slice_b, slice_s;
   logic             slice_cout;

   always_comb begin
      grant_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant_q;
      end else begin
         grant_id = req1_valid;
      end
   end

   assign req0_ready = (state_q == IDLE) && grant_vld && (grant_id == 1'b0);
   assign req1_ready = (state_q == IDLE) && grant_vld && (grant_id == 1'b1);

`ifdef NIBBLE_SCHED_INC_EN
   assign inc_sel = grant_id ? req1_inc : req0_inc;
`else
   assign inc_sel = 1'b0;
`endif

   assign nib_base = int'(nib_cnt_q) * NIB_W;
   assign slice_a  = a_q[nib_base +: NIB_W];
   assign slice_b  = b_q[nib_base +: NIB_W];

   nibble_add4 u_add4 (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      sum_d        = sum_q;
      carry_d      = carry_q;
      nib_cnt_d    = nib_cnt_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               a_d       = grant_id ? req1_a : req0_a;
               b_d       = grant_id ? req1_b : req0_b;
               id_d      = grant_id;
               carry_d   = inc_sel;
               nib_cnt_d = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            // carry_q ends up holding the top-nibble carry, which is rsp_cout in DONE.
            sum_d[nib_base +: NIB_W] = slice_s;
            carry_d   = slice_cout;
            nib_cnt_d = nib_cnt_q + 1'b1;
            if (nib_cnt_q == CNT_W'(NIB - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d      = IDLE;
               last_grant_d = id_q;
            end
         end
         default: state_d = IDLE;
      endcase
      rsp_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         carry_q      <= 1'b0;
         nib_cnt_q    <= '0;
         rsp_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sum_q        <= sum_d;
         carry_q      <= carry_d;
         nib_cnt_q    <= nib_cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = carry_q;
   assign rsp_id    = id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed bench for nibble_add_sched with a result scoreboard; covers NIBBLE_SCHED_INC_EN when defined.
module tb_nibble_add_sched;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             id;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             req0_inc, req1_inc;
   logic             rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
   logic [WIDTH-1:0] rsp_sum;

   exp_t sb[$];
   exp_t last_exp;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   nibble_add_sched #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
`ifdef NIBBLE_SCHED_INC_EN
      .req0_inc   (req0_inc),
      .req1_inc   (req1_inc),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic inc, input logic id);
      logic [WIDTH:0] full;
      exp_t           e;
      full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, inc};
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.id   = id;
      return e;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic compare_pop(input string tag);
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
         failures++;
         $error("FAIL %s_sb: observed=unexpected response expected=none pending", tag);
      end
      if (sb.size() > 0) begin
         e        = sb.pop_front();
         last_exp = e;
         check({tag, "_sum"}, rsp_sum, e.sum);
         check({tag, "_cout"}, rsp_cout, e.cout);
         check({tag, "_id"}, rsp_id, e.id);
      end
   endtask

   task automatic do_req(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic inc);
      req0_valid = (id == 1'b0);
      req1_valid = (id == 1'b1);
      if (id == 1'b0) begin
         req0_a = a;
         req0_b = b;
      end else begin
         req1_a = a;
         req1_b = b;
      end
      req0_inc = inc;
      req1_inc = inc;
      #1;
      check("accept_ready", id ? req1_ready : req0_ready, 1);
      sb.push_back(model(a, b, inc, id));
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int lat = 0;
      while (!rsp_valid && lat < 20) begin
         cyc();
         lat++;
      end
      check({tag, "_lat"}, lat, NIB);
      if (rsp_valid) compare_pop(tag);
   endtask

   initial begin
      logic             exp_rr;
      int               n_acc, n_rsp, last_acc, seen;
      logic [WIDTH-1:0] a0, b0, a1, b1;

      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a     = '0;
      req0_b     = '0;
      req1_a     = '0;
      req1_b     = '0;
      req0_inc   = 1'b0;
      req1_inc   = 1'b0;
      rsp_ready  = 1'b1;
      cyc();
      cyc();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_sum", rsp_sum, 0);
      check("rst_rsp_cout", rsp_cout, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_busy", busy, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      rst_n = 1'b1;
      cyc();

      do_req(1'b0, 16'h1234, 16'h1111, 1'b0);
      check("basic_busy", busy, 1);
      wait_rsp("basic");
      check("basic_literal", rsp_sum, 16'h2345);
      cyc();
      check("basic_idle", busy, 0);

      do_req(1'b1, 16'h00FF, 16'h0001, 1'b0);
      wait_rsp("ripple_mid");
      check("ripple_mid_literal", rsp_sum, 16'h0100);
      cyc();
      do_req(1'b0, 16'hFFFF, 16'h0001, 1'b0);
      wait_rsp("ripple_wrap");
      check("ripple_wrap_cout", rsp_cout, 1);
      cyc();
      do_req(1'b1, 16'hABCD, 16'h1234, 1'b0);
      wait_rsp("req1_add");
      cyc();

      // Round robin from reset with both requesters held valid.
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      a0 = 16'h0102; b0 = 16'h0304;
      a1 = 16'h8000; b1 = 16'h8001;
      req0_a = a0; req0_b = b0;
      req1_a = a1; req1_b = b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      exp_rr   = 1'b0;
      n_acc    = 0;
      n_rsp    = 0;
      last_acc = 0;
      for (int c = 0; c < 100 && n_rsp < 4; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            check("rr_id", req1_ready, exp_rr);
            check("rr_one_hot", req0_ready & req1_ready, 0);
            if (n_acc > 0) check("rr_period", c - last_acc, NIB + 2);
            sb.push_back(exp_rr ? model(a1, b1, 1'b0, 1'b1) : model(a0, b0, 1'b0, 1'b0));
            last_acc = c;
            n_acc++;
            exp_rr = ~exp_rr;
         end
         if (rsp_valid) begin
            compare_pop("rr_rsp");
            n_rsp++;
         end
         cyc();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("rr_count", n_rsp, 4);

      rsp_ready = 1'b0;
      do_req(1'b0, 16'h4321, 16'h0F0F, 1'b0);
      wait_rsp("bp");
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (5) begin
         cyc();
         #1;
         check("bp_valid", rsp_valid, 1);
         check("bp_sum", rsp_sum, last_exp.sum);
         check("bp_cout", rsp_cout, last_exp.cout);
         check("bp_id", rsp_id, last_exp.id);
         check("bp_req0_ready", req0_ready, 0);
         check("bp_req1_ready", req1_ready, 0);
      end
      rsp_ready  = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      cyc();
      check("bp_release_busy", busy, 0);
      check("bp_release_valid", rsp_valid, 0);

      do_req(1'b1, 16'h5555, 16'h2222, 1'b0);
      cyc();
      rst_n = 1'b0;
      cyc();
      sb.delete();
      rst_n = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", rsp_valid, 0);
      seen = 0;
      repeat (8) begin
         cyc();
         if (rsp_valid) seen++;
      end
      check("midrst_no_rsp", seen, 0);
      req0_a = 16'h0A0A; req0_b = 16'h0505;
      req1_a = 16'h7777; req1_b = 16'h1111;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check("midrst_req0_ready", req0_ready, 1);
      check("midrst_req1_ready", req1_ready, 0);
      sb.push_back(model(16'h0A0A, 16'h0505, 1'b0, 1'b0));
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp("midrst_after");
      cyc();

`ifdef NIBBLE_SCHED_INC_EN
      do_req(1'b0, 16'hFFFE, 16'h0000, 1'b1);
      wait_rsp("inc_nowrap");
      check("inc_nowrap_literal", rsp_sum, 16'hFFFF);
      cyc();
      do_req(1'b1, 16'hFFFF, 16'h0000, 1'b1);
      wait_rsp("inc_wrap");
      check("inc_wrap_cout", rsp_cout, 1);
      cyc();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
